audio_frame_ctrl: RTL and testbench
===================================

// Module: audio_frame_ctrl
// PURPOSE
//  Per-frame scheduler for the audio DSP datapath. On each I2S start-of-frame it
//  sequences the channel capture writes into the audio input RAM, holds the
//  sequencer in reset, then releases it and waits for completion.
//  Applies host coefficient-bank switches only at a frame boundary, and flags overruns.
//  Sits between i2s_clock/i2s_rx, the audio input dpram, the sequencer and the status registers.
// PARAMETERS
//  CHANNELS      8   audio channels captured per frame
//  CHAN_W        3   $clog2(CHANNELS)
//  FRAME_W       8   frame counter width (256-frame ring)
//  RESET_CYCLES  2   cycles eng_rst is held after capture (min 1)
// PORTS
//  ck             in   1        system clock
//  rst            in   1        asynchronous, active-high reset
//  start_of_frame in   1        1-cycle pulse from I2S clocking
//  host_mode      in   1        host owns audio RAM; frame capture suspended
//  host_run       in   1        pulse: run engine once without capture (host_mode only)
//  bank_req       in   1        pulse: request coefficient bank switch
//  eng_done       in   1        pulse: sequencer/spl transfer finished
//  eng_error      in   1        pulse: sequencer error
//  flag_clr       in   1        clears overrun and err_flag
//  wr_en          out  1        audio RAM write strobe
//  wr_chan        out  CHAN_W   channel being written (mic mux select and addr MSBs)
//  frame          out  FRAME_W  current frame index (addr LSBs, sequencer frame)
//  eng_rst        out  1        sequencer / spl_xfer reset
//  bank           out  1        coefficient bank read by the engine
//  bank_pending   out  1        switch requested, not yet applied
//  done           out  1        1-cycle pulse at end of a run
//  overrun        out  1        sticky: frame arrived while not IDLE
//  err_flag       out  1        sticky: eng_error seen during RUN
// BEHAVIOUR
//  Reset values: IDLE, frame=0, wr_chan=0, wr_en=0, eng_rst=1, bank=0; all flags and done = 0.
//  States: IDLE -> CAPTURE -> RESET -> RUN -> IDLE. wr_en=(CAPTURE); eng_rst=!(RUN).
//  IDLE:
//   - start_of_frame && !host_mode: frame <= frame-1 (wraps 0->255), wr_chan <= 0, go to CAPTURE.
//   - host_run && host_mode: go to RESET; frame unchanged.
//   - start_of_frame && host_mode: ignored, no overrun.
//  CAPTURE: exactly CHANNELS cycles, wr_chan 0..CHANNELS-1, then RESET.
//   - host_mode rising mid-CAPTURE does not abort; all CHANNELS writes complete.
//  RESET: exactly RESET_CYCLES cycles, then RUN.
//   - On entry, if bank_pending: bank toggles and bank_pending clears.
//  RUN: on eng_done or eng_error, done pulses for 1 cycle and state goes to IDLE.
//   - eng_error also sets err_flag.
//   - eng_done outside RUN is ignored.
//  Latency: start_of_frame sampled at edge T -> wr_en high T+1..T+CHANNELS.
//   - RESET follows for RESET_CYCLES cycles; eng_rst falls at T+1+CHANNELS+RESET_CYCLES (T+11 default).
//  Overrun: start_of_frame in CAPTURE/RESET/RUN (with !host_mode) sets overrun.
//   - That frame is skipped: frame is not decremented and the current run continues.
//  bank_req sets bank_pending.
//   - bank_req in the same cycle as an apply merges into it: one toggle, pending ends 0.
//  flag_clr clears both sticky flags; a set event in the same cycle wins.
//  rst mid-operation: immediate return to reset values; bank returns to 0.
// STRUCTURE
//  Shared header audio_defs.vh: CHANNELS, FRAME_W, state encodings
//   (IDLE=0, CAPTURE=1, RESET=2, RUN=3).
//  Sub-module bank_switch: bank_pending/bank toggle with merge rule.
//  Everything else stays in this module.
// TESTING
//  1. After rst, one start_of_frame -> wr_chan 0..7 over 8 cycles, frame=255, eng_rst low 11 cycles after the sampling edge.
//  2. eng_done in RUN -> done 1 cycle, IDLE; a second frame -> frame=254.
//  3. start_of_frame during RUN -> overrun=1, frame unchanged, no wr_en; flag_clr -> overrun=0.
//  4. bank_req during RUN -> bank_pending=1, bank=0; next frame's RESET entry -> bank=1, pending=0.
//     bank_req on the apply cycle -> single toggle.
//  5. host_mode=1, start_of_frame -> ignored; host_run -> RESET then RUN, no wr_en, frame unchanged.
//  6. Assert rst mid-CAPTURE (wr_chan=4) -> wr_en=0, eng_rst=1, frame=0, bank=0 asynchronously.
//     After release, a full frame capture behaves as in test 1.

Source files
------------

// File: rtl/audio_frame_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// audio_frame_ctrl_pkg
// Shared constants and types for the audio frame scheduler:
//   - frame geometry (channel count, channel/frame index widths)
//   - sequencer reset hold length and its counter width
//   - scheduler state encoding (IDLE=0, CAPTURE=1, RESET=2, RUN=3)
//   - small helper to detect the last channel of a capture
// -----------------------------------------------------------------------------
package audio_frame_ctrl_pkg;

    localparam int CHANNELS     = 8;
    localparam int CHAN_W       = $clog2(CHANNELS);
    localparam int FRAME_W      = 8;
    localparam int RESET_CYCLES = 2;
    localparam int RST_CNT_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_RESET   = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

    // True on the final channel write of a capture burst.
    function automatic logic is_last_chan(input logic [CHAN_W-1:0] chan);
        return (chan == CHAN_W'(CHANNELS - 1));
    endfunction

endpackage

// File: rtl/audio_frame_ctrl_bank_switch.sv
// -----------------------------------------------------------------------------
// bank_switch
// Holds a host coefficient-bank switch request until the scheduler reaches a
// frame boundary (entry into RESET), then flips the active bank.
// Ports:
//   ck             in   system clock
//   rst            in   asynchronous active-high reset
//   bank_req_i     in   pulse: host requests a bank switch
//   apply_i        in   pulse: scheduler is entering RESET this cycle
//   bank_o         out  active coefficient bank
//   bank_pending_o out  request seen but not yet applied
// A request arriving on the apply cycle is folded into that apply: the bank
// toggles once and nothing remains pending.
// -----------------------------------------------------------------------------
module bank_switch
    import audio_frame_ctrl_pkg::*;
(
    input  logic ck,
    input  logic rst,
    input  logic bank_req_i,
    input  logic apply_i,
    output logic bank_o,
    output logic bank_pending_o
);

    logic bank_q;
    logic bank_d;
    logic pending_q;
    logic pending_d;

    // Next-state for the active bank and the pending request.
    always_comb begin
        bank_d    = bank_q;
        pending_d = pending_q;
        if (apply_i && (pending_q || bank_req_i)) begin
            bank_d    = ~bank_q;
            pending_d = 1'b0;
        end else if (bank_req_i) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

    // Bank and pending registers.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            bank_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            bank_q    <= bank_d;
            pending_q <= pending_d;
        end
    end

    assign bank_o         = bank_q;
    assign bank_pending_o = pending_q;

endmodule

// File: rtl/audio_frame_ctrl.sv
// -----------------------------------------------------------------------------
// audio_frame_ctrl
// Per-frame scheduler for the audio DSP datapath. Each I2S start-of-frame
// launches a capture burst into the audio input RAM (one write per channel),
// then holds the sequencer in reset for a fixed number of cycles, releases it
// and waits for completion. Coefficient bank switches are applied only on
// entry to RESET. Frames arriving while busy are dropped and flagged.
// Ports:
//   ck, rst          clock, asynchronous active-high reset
//   start_of_frame   1-cycle I2S frame pulse
//   host_mode        host owns the audio RAM; captures suspended
//   host_run         pulse: run engine without capture (host_mode only)
//   bank_req         pulse: request coefficient bank switch
//   eng_done         pulse: engine finished
//   eng_error        pulse: engine error
//   flag_clr         clears overrun and err_flag
//   wr_en, wr_chan   audio RAM write strobe and channel select
//   frame            current frame index (counts down, 256-frame ring)
//   eng_rst          sequencer reset (low only in RUN)
//   bank, bank_pending  active coefficient bank / switch waiting
//   done             1-cycle end-of-run pulse
//   overrun, err_flag   sticky status flags
// All outputs are registered.
// -----------------------------------------------------------------------------
module audio_frame_ctrl
    import audio_frame_ctrl_pkg::*;
(
    input  logic               ck,
    input  logic               rst,
    input  logic               start_of_frame,
    input  logic               host_mode,
    input  logic               host_run,
    input  logic               bank_req,
    input  logic               eng_done,
    input  logic               eng_error,
    input  logic               flag_clr,
    output logic               wr_en,
    output logic [CHAN_W-1:0]  wr_chan,
    output logic [FRAME_W-1:0] frame,
    output logic               eng_rst,
    output logic               bank,
    output logic               bank_pending,
    output logic               done,
    output logic               overrun,
    output logic               err_flag
);

    state_e                state_q;
    state_e                state_d;
    logic [CHAN_W-1:0]     wr_chan_q;
    logic [CHAN_W-1:0]     wr_chan_d;
    logic [FRAME_W-1:0]    frame_q;
    logic [FRAME_W-1:0]    frame_d;
    logic [RST_CNT_W-1:0]  rst_cnt_q;
    logic [RST_CNT_W-1:0]  rst_cnt_d;
    logic                  wr_en_q;
    logic                  eng_rst_q;
    logic                  done_q;
    logic                  done_d;
    logic                  overrun_q;
    logic                  overrun_d;
    logic                  err_q;
    logic                  err_d;
    logic                  apply_s;
    logic                  frame_req_s;

    // A frame only counts when the host does not own the RAM.
    assign frame_req_s = start_of_frame && !host_mode;

    // Scheduler next-state: state, channel/frame indices and reset hold count.
    always_comb begin
        state_d   = state_q;
        wr_chan_d = wr_chan_q;
        frame_d   = frame_q;
        rst_cnt_d = rst_cnt_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_req_s) begin
                    state_d   = ST_CAPTURE;
                    frame_d   = frame_q - FRAME_W'(1);
                    wr_chan_d = CHAN_W'(0);
                end else if (host_run && host_mode) begin
                    state_d   = ST_RESET;
                    rst_cnt_d = RST_CNT_W'(0);
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                // host_mode is deliberately not consulted: a started burst completes.
                if (is_last_chan(wr_chan_q)) begin
                    state_d   = ST_RESET;
                    rst_cnt_d = RST_CNT_W'(0);
                end else begin
                    wr_chan_d = wr_chan_q + CHAN_W'(1);
                end
            end
            ST_RESET: begin
                if (rst_cnt_q == RST_CNT_W'(RESET_CYCLES - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (eng_done || eng_error) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky flags: a set event in the same cycle as flag_clr wins.
    always_comb begin
        overrun_d = overrun_q;
        err_d     = err_q;
        if (frame_req_s && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end else if (flag_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
        if ((state_q == ST_RUN) && eng_error) begin
            err_d = 1'b1;
        end else if (flag_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Bank switches land on the edge that enters RESET (frame boundary).
    assign apply_s = (state_d == ST_RESET) && (state_q != ST_RESET);

    // Scheduler registers; wr_en/eng_rst are decoded from the next state so
    // they line up with the state they describe.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wr_chan_q <= CHAN_W'(0);
            frame_q   <= FRAME_W'(0);
            rst_cnt_q <= RST_CNT_W'(0);
            wr_en_q   <= 1'b0;
            eng_rst_q <= 1'b1;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_chan_q <= wr_chan_d;
            frame_q   <= frame_d;
            rst_cnt_q <= rst_cnt_d;
            wr_en_q   <= (state_d == ST_CAPTURE);
            eng_rst_q <= (state_d != ST_RUN);
            done_q    <= done_d;
            overrun_q <= overrun_d;
            err_q     <= err_d;
        end
    end

    bank_switch u_bank_switch (
        .ck             (ck),
        .rst            (rst),
        .bank_req_i     (bank_req),
        .apply_i        (apply_s),
        .bank_o         (bank),
        .bank_pending_o (bank_pending)
    );

    assign wr_en    = wr_en_q;
    assign wr_chan  = wr_chan_q;
    assign frame    = frame_q;
    assign eng_rst  = eng_rst_q;
    assign done     = done_q;
    assign overrun  = overrun_q;
    assign err_flag = err_q;

endmodule

// File: tb/tb_audio_frame_ctrl.sv
// Directed bench for audio_frame_ctrl. Inputs change 1 ns after a rising edge;
// outputs are read at that point, i.e. the value a consumer clocked on the
// next edge would see.
module tb_audio_frame_ctrl;

    logic       ck = 1'b0;
    logic       rst;
    logic       start_of_frame;
    logic       host_mode;
    logic       host_run;
    logic       bank_req;
    logic       eng_done;
    logic       eng_error;
    logic       flag_clr;
    logic       wr_en;
    logic [2:0] wr_chan;
    logic [7:0] frame;
    logic       eng_rst;
    logic       bank;
    logic       bank_pending;
    logic       done;
    logic       overrun;
    logic       err_flag;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 ck = ~ck;

    audio_frame_ctrl dut (
        .ck             (ck),
        .rst            (rst),
        .start_of_frame (start_of_frame),
        .host_mode      (host_mode),
        .host_run       (host_run),
        .bank_req       (bank_req),
        .eng_done       (eng_done),
        .eng_error      (eng_error),
        .flag_clr       (flag_clr),
        .wr_en          (wr_en),
        .wr_chan        (wr_chan),
        .frame          (frame),
        .eng_rst        (eng_rst),
        .bank           (bank),
        .bank_pending   (bank_pending),
        .done           (done),
        .overrun        (overrun),
        .err_flag       (err_flag)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    // Full frame: 8 writes, then eng_rst must first be seen low at edge T+11.
    task automatic run_capture(input logic [7:0] exp_frame);
        int n;
        start_of_frame = 1'b1;
        step();
        start_of_frame = 1'b0;
        check_val("cap_frame", frame, exp_frame);
        for (int i = 0; i < 8; i++) begin
            check_val("cap_wr_en", wr_en, 1);
            check_val("cap_wr_chan", wr_chan, i);
            step();
        end
        check_val("cap_wr_en_off", wr_en, 0);
        check_val("cap_eng_rst_hold", eng_rst, 1);
        n = 8;
        while (eng_rst && n < 30) begin
            step();
            n++;
        end
        check_val("eng_rst_fall_edge", n + 1, 11);
    endtask

    // End a run with eng_done: one done pulse, back to IDLE.
    task automatic finish_run();
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        check_val("done_pulse", done, 1);
        check_val("idle_eng_rst", eng_rst, 1);
        step();
        check_val("done_clear", done, 0);
    endtask

    initial begin
        rst = 1'b1;
        start_of_frame = 1'b0; host_mode = 1'b0; host_run = 1'b0; bank_req = 1'b0;
        eng_done = 1'b0; eng_error = 1'b0; flag_clr = 1'b0;
        #12;
        // Reset values.
        check_val("rst_wr_en", wr_en, 0);
        check_val("rst_eng_rst", eng_rst, 1);
        check_val("rst_frame", frame, 0);
        check_val("rst_wr_chan", wr_chan, 0);
        check_val("rst_bank", bank, 0);
        check_val("rst_pending", bank_pending, 0);
        check_val("rst_flags", {29'd0, done, overrun, err_flag}, 0);
        @(negedge ck);
        rst = 1'b0;
        step();

        // 1/2: two frames, counting down from 0 with wrap.
        run_capture(8'd255);
        finish_run();
        run_capture(8'd254);
        finish_run();

        // eng_done while IDLE is ignored.
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        check_val("idle_done_ignored", done, 0);

        // 3: overrun while running; frame kept, no writes, run continues.
        run_capture(8'd253);
        start_of_frame = 1'b1;
        step();
        start_of_frame = 1'b0;
        check_val("ovr_set", overrun, 1);
        check_val("ovr_frame", frame, 253);
        check_val("ovr_wr_en", wr_en, 0);
        check_val("ovr_still_run", eng_rst, 0);
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        check_val("ovr_clr", overrun, 0);
        start_of_frame = 1'b1; flag_clr = 1'b1;
        step();
        start_of_frame = 1'b0; flag_clr = 1'b0;
        check_val("ovr_set_wins", overrun, 1);
        // Error ends the run and sets err_flag.
        eng_error = 1'b1;
        step();
        eng_error = 1'b0;
        check_val("err_done", done, 1);
        check_val("err_flag_set", err_flag, 1);
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        check_val("err_flag_clr", err_flag, 0);
        check_val("ovr_clr2", overrun, 0);

        // 4: bank request in RUN applies at next frame's RESET entry.
        run_capture(8'd252);
        bank_req = 1'b1;
        step();
        bank_req = 1'b0;
        check_val("bank_pend_set", bank_pending, 1);
        check_val("bank_not_yet", bank, 0);
        finish_run();
        run_capture(8'd251);
        check_val("bank_applied", bank, 1);
        check_val("bank_pend_clr", bank_pending, 0);
        finish_run();

        // 5: host mode; frame pulses ignored, host_run skips capture.
        host_mode = 1'b1;
        start_of_frame = 1'b1;
        step();
        start_of_frame = 1'b0;
        check_val("host_sof_wr_en", wr_en, 0);
        check_val("host_sof_eng_rst", eng_rst, 1);
        check_val("host_sof_overrun", overrun, 0);
        check_val("host_sof_frame", frame, 251);
        // Pending request plus a new one on the apply cycle: one toggle.
        bank_req = 1'b1;
        step();
        bank_req = 1'b1; host_run = 1'b1;
        step();
        bank_req = 1'b0; host_run = 1'b0;
        check_val("merge_bank", bank, 0);
        check_val("merge_pending", bank_pending, 0);
        check_val("host_reset_wr_en", wr_en, 0);
        step();
        check_val("host_reset_hold", eng_rst, 1);
        step();
        check_val("host_run_eng_rst", eng_rst, 0);
        check_val("host_run_frame", frame, 251);
        check_val("host_run_wr_en", wr_en, 0);
        finish_run();
        // Leave bank=1 for the reset check.
        bank_req = 1'b1;
        step();
        bank_req = 1'b0; host_run = 1'b1;
        step();
        host_run = 1'b0;
        check_val("host_bank1", bank, 1);
        step();
        step();
        finish_run();
        host_mode = 1'b0;

        // 6: asynchronous reset mid-capture.
        start_of_frame = 1'b1;
        step();
        start_of_frame = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check_val("pre_rst_chan", wr_chan, 4);
        #2 rst = 1'b1;
        #1;
        check_val("arst_wr_en", wr_en, 0);
        check_val("arst_eng_rst", eng_rst, 1);
        check_val("arst_frame", frame, 0);
        check_val("arst_bank", bank, 0);
        @(negedge ck);
        rst = 1'b0;
        step();
        run_capture(8'd255);
        finish_run();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
